// File: rtl/death_ctrl.sv
// death_ctrl: game-state sequencer for kid death, game-over overlay,
// stage reset back to the hazards, and a saturating BCD death counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_PLAY    | normal play; watches collide flags and restart edges
// ST_DYING   | kid frozen and blinking, counting frame ticks
// ST_OVER    | game-over overlay shown, kid hidden, waiting for restart
// ST_RESPAWN | stage_rst held until a frame tick has been seen, plus one
module death_ctrl #(
   parameter int N_HAZ        = 8,
   parameter int DYING_FRAMES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic [N_HAZ-1:0] collide,
   input  logic             restart_key,
   output logic             kid_freeze,
   output logic             kid_flash,
   output logic             show_game_over,
   output logic             stage_rst,
   output logic [15:0]      death_count
);

   localparam logic [1:0] ST_PLAY    = 2'd0;
   localparam logic [1:0] ST_DYING   = 2'd1;
   localparam logic [1:0] ST_OVER    = 2'd2;
   localparam logic [1:0] ST_RESPAWN = 2'd3;

   localparam logic [7:0] DYING_LAST = 8'(DYING_FRAMES);

   logic [1:0]  state_q, state_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        blink_q, blink_d;
   logic        key_q, key_d;
   logic        seen_q, seen_d;
   logic [15:0] count_q, count_d;
   logic        freeze_q, freeze_d;
   logic        flash_q, flash_d;
   logic        over_q, over_d;
   logic        srst_q, srst_d;
   logic        restart_edge;

   // Per-digit BCD increment; 9999 is sticky.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   assign restart_edge = restart_key & ~key_q;

   // Next-state, counters and registered-output values derived from the next state.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      blink_d     = blink_q;
      count_d     = count_q;
      seen_d      = 1'b0;
      key_d       = restart_key;

      case (state_q)
         ST_PLAY: begin
            if (restart_edge) begin
               state_d = ST_RESPAWN;
            end else if (|collide) begin
               state_d     = ST_DYING;
               count_d     = bcd_inc(count_q);
               frame_cnt_d = 8'd0;
               blink_d     = 1'b0;
            end
         end
         ST_DYING: begin
            if (restart_edge) begin
               state_d = ST_RESPAWN;
            end else if (frame_tick) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               blink_d     = ~blink_q;
               if (frame_cnt_q + 8'd1 == DYING_LAST) begin
                  state_d = ST_OVER;
               end
            end
         end
         ST_OVER: begin
            if (restart_edge) begin
               state_d = ST_RESPAWN;
            end
         end
         default: begin
            // One extra cycle after the tick so slow hazard logic sees stage_rst.
            if (seen_q) begin
               state_d = ST_PLAY;
            end else begin
               seen_d = frame_tick;
            end
         end
      endcase

      freeze_d = (state_d != ST_PLAY);
      over_d   = (state_d == ST_OVER);
      srst_d   = (state_d == ST_RESPAWN);
      flash_d  = 1'b0;
      if (state_d == ST_OVER) begin
         flash_d = 1'b1;
      end else if (state_d == ST_DYING) begin
         flash_d = blink_d;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_PLAY;
         frame_cnt_q <= 8'd0;
         blink_q     <= 1'b0;
         key_q       <= 1'b1;
         seen_q      <= 1'b0;
         count_q     <= 16'h0000;
         freeze_q    <= 1'b0;
         flash_q     <= 1'b0;
         over_q      <= 1'b0;
         srst_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         blink_q     <= blink_d;
         key_q       <= key_d;
         seen_q      <= seen_d;
         count_q     <= count_d;
         freeze_q    <= freeze_d;
         flash_q     <= flash_d;
         over_q      <= over_d;
         srst_q      <= srst_d;
      end
   end

   assign kid_freeze     = freeze_q;
   assign kid_flash      = flash_q;
   assign show_game_over = over_q;
   assign stage_rst      = srst_q;
   assign death_count    = count_q;

endmodule

// File: tb/tb_death_ctrl.sv
// Scoreboard bench for death_ctrl: a behavioural model pushes the expected
// outputs for each cycle, a monitor pops and compares after each edge.
module tb_death_ctrl;

   localparam int NH = 8;
   localparam int DF = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_tick = 1'b0;
   logic [NH-1:0] collide = '0;
   logic          restart_key = 1'b0;
   logic          kid_freeze, kid_flash, show_game_over, stage_rst;
   logic [15:0]   death_count;

   death_ctrl #(.N_HAZ(NH), .DYING_FRAMES(DF)) dut (
      .clk            (clk),
      .rst            (rst),
      .frame_tick     (frame_tick),
      .collide        (collide),
      .restart_key    (restart_key),
      .kid_freeze     (kid_freeze),
      .kid_flash      (kid_flash),
      .show_game_over (show_game_over),
      .stage_rst      (stage_rst),
      .death_count    (death_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        freeze;
      logic        flash;
      logic        over;
      logic        srst;
      logic [15:0] count;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   typedef enum {M_PLAY, M_DYING, M_OVER, M_RESPAWN} mode_t;
   mode_t m_mode   = M_PLAY;
   int    m_ticks  = 0;
   int    m_deaths = 0;
   bit    m_key    = 1'b1;
   bit    m_seen   = 1'b0;

   task automatic model(input logic r, input logic t, input logic [NH-1:0] c, input logic k);
      bit edge_seen;
      if (r) begin
         m_mode = M_PLAY; m_ticks = 0; m_deaths = 0; m_key = 1'b1; m_seen = 1'b0;
      end else begin
         edge_seen = k && !m_key;
         m_key = k;
         case (m_mode)
            M_PLAY: begin
               if (edge_seen) begin
                  m_mode = M_RESPAWN; m_seen = 1'b0;
               end else if (c != 0) begin
                  m_mode = M_DYING; m_ticks = 0;
                  if (m_deaths < 9999) m_deaths++;
               end
            end
            M_DYING: begin
               if (edge_seen) begin
                  m_mode = M_RESPAWN; m_seen = 1'b0;
               end else if (t) begin
                  m_ticks++;
                  if (m_ticks == DF) m_mode = M_OVER;
               end
            end
            M_OVER: begin
               if (edge_seen) begin
                  m_mode = M_RESPAWN; m_seen = 1'b0;
               end
            end
            M_RESPAWN: begin
               if (m_seen) m_mode = M_PLAY;
               else if (t) m_seen = 1'b1;
            end
         endcase
      end
   endtask

   function automatic exp_t expected();
      exp_t e;
      int   d;
      d        = m_deaths;
      e.freeze = (m_mode != M_PLAY);
      e.over   = (m_mode == M_OVER);
      e.srst   = (m_mode == M_RESPAWN);
      e.flash  = (m_mode == M_OVER) || (m_mode == M_DYING && (m_ticks % 2) == 1);
      e.count  = {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
      return e;
   endfunction

   task automatic step(input logic r, input logic t, input logic [NH-1:0] c, input logic k);
      @(negedge clk);
      rst = r; frame_tick = t; collide = c; restart_key = k;
      model(r, t, c, k);
      exp_q.push_back(expected());
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   // Monitor: one expected record per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("kid_freeze",     16'(kid_freeze),     16'(e.freeze));
            chk("kid_flash",      16'(kid_flash),      16'(e.flash));
            chk("show_game_over", 16'(show_game_over), 16'(e.over));
            chk("stage_rst",      16'(stage_rst),      16'(e.srst));
            chk("death_count",    death_count,         e.count);
         end
      end
   end

   initial begin
      logic            key_r;
      logic [NH-1:0]   c_r;

      repeat (3) step(1, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0);

      // Death and a full DYING sequence with ticks 10 cycles apart.
      step(0, 0, 8'h04, 0);
      repeat (DF) begin
         repeat (9) step(0, 0, 0, 0);
         step(0, 1, 0, 0);
      end
      repeat (3) step(0, 0, 0, 0);

      // Restart from OVER, key held through respawn and afterwards.
      step(0, 0, 0, 1);
      repeat (5) step(0, 0, 0, 1);
      step(0, 1, 0, 1);
      repeat (5) step(0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0);

      // Restart edge with collide in the same PLAY cycle.
      step(0, 0, 8'hFF, 1);
      step(0, 1, 0, 1);
      repeat (3) step(0, 0, 0, 0);

      // Collide held through DYING, OVER and RESPAWN.
      step(0, 0, 8'h01, 0);
      repeat (DF) begin
         step(0, 1, 8'h80, 0);
         step(0, 0, 8'h80, 0);
      end
      repeat (2) step(0, 0, 8'h80, 0);
      step(0, 0, 8'h80, 1);
      step(0, 0, 8'h80, 1);
      step(0, 1, 8'h80, 1);
      step(0, 0, 8'h80, 1);
      repeat (2) step(0, 0, 0, 0);

      // Key held through reset, then rst mid-RESPAWN.
      repeat (2) step(1, 0, 0, 1);
      repeat (5) step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 8'h02, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);

      // Randomized traffic.
      key_r = 1'b0;
      repeat (3000) begin
         if ($urandom_range(0, 19) == 0) key_r = ~key_r;
         c_r = ($urandom_range(0, 9) == 0) ? NH'($urandom) : '0;
         step(($urandom_range(0, 699) == 0), ($urandom_range(0, 4) == 0), c_r, key_r);
      end

      // Rapid deaths through the 0099->0100 carry and into saturation.
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      repeat (10005) begin
         step(0, 0, 8'h01, 0);
         step(0, 0, 0, 1);
         step(0, 1, 0, 0);
         step(0, 0, 0, 0);
      end
      repeat (3) step(0, 0, 0, 0);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
